// File: rtl/rr_enc_pkg.sv
// rtl/rr_enc_pkg.sv - shared types and helpers for the round-robin encoder
//
// Purpose: holds the default request count, the index-width helper, the
// one-hot expansion shared with the 2-to-4 decoder side, and the state type
// of the encoder output stage.
// Ports: none (package).
package rr_enc_pkg;

   localparam int N_DEFAULT = 4;

   // Widest request vector that onehot() can expand into.
   localparam int N_MAX = 32;

   // Output stage holder: EMPTY means valid=0, FULL means idx is on offer.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   // Index width for n request lines. At least 1 bit, so that n=1 still
   // yields a legal vector width.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Binary index to one-hot vector. Callers truncate the result to their
   // own request width.
   function automatic logic [N_MAX-1:0] onehot(input int unsigned i);
      return N_MAX'(1) << i;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick of one pending bit
//
// Purpose: rotating priority search. Starting at ptr and wrapping modulo N,
// it returns the first set bit of pending. This block has no state, so an
// arbiter can reuse it with its own pointer register.
// Ports:
//   pending  in  N  candidate bits
//   ptr      in  W  highest-priority position for this search
//   sel      out W  index of the first set bit at or after ptr (0 when none)
//   has_sel  out 1  at least one bit of pending is set
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] sel,
   output logic         has_sel
);

   logic [W-1:0] cand;
   logic         found;

   // N is a power of two, so the W-bit sum ptr+i wraps modulo N by itself.
   always_comb begin
      sel     = '0;
      cand    = '0;
      found   = 1'b0;
      has_sel = |pending;
      for (int i = 0; i < N; i++) begin
         cand = ptr + W'(i);
         if (!found && pending[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_encoder_4_2.sv
// rtl/rr_encoder_4_2.sv - sequential round-robin 4-to-2 encoder with valid/ready output
//
// Purpose: latches request pulses into a pending register. It serves one
// pending bit per transfer, in round-robin order, as a binary index on a
// valid/ready handshake.
// Ports:
//   clk          in  1  rising-edge clock
//   rst          in  1  synchronous active-high reset
//   req          in  N  request pulses, one wire per source
//   idx          out W  encoded source index, meaningful while valid=1
//   valid        out 1  idx holds an unconsumed index
//   ready        in  1  consumer takes idx in any cycle with valid && ready
//   any_pending  out 1  OR of the pending register (excludes the presented bit)
//   drop         out 1  one-cycle pulse: a request merged into an already pending bit
module rr_encoder_4_2
   import rr_enc_pkg::*;
#(
   parameter int  N = N_DEFAULT,
   localparam int W = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid,
   input  logic         ready,
   output logic         any_pending,
   output logic         drop
);

   // N must be a power of two and at least 2. rr_pick relies on the
   // W-bit pointer wrapping modulo N.

   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] idx_q, idx_d;
   out_state_e   out_q, out_d;
   logic         drop_q, drop_d;

   logic [W-1:0] sel;
   logic         has_sel;
   logic         load;
   logic [N-1:0] clr;

   rr_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .pending (pending_q),
      .ptr     (ptr_q),
      .sel     (sel),
      .has_sel (has_sel)
   );

   always_comb begin
      out_d = out_q;
      idx_d = idx_q;
      ptr_d = ptr_q;
      clr   = '0;
      // Refill the output stage when it is empty or is being emptied this
      // cycle.
      load  = has_sel && ((out_q == OUT_EMPTY) || ready);

      if (load) begin
         clr   = N'(onehot(32'(sel)));
         idx_d = sel;
         ptr_d = sel + W'(1);
         out_d = OUT_FULL;
      end else if ((out_q == OUT_FULL) && ready) begin
         // Drain with nothing left to serve. idx keeps its old value.
         out_d = OUT_EMPTY;
      end

      // OR-ing req in after the clear gives a new request priority over the
      // bit being moved out. That source is then served again later.
      pending_d = (pending_q & ~clr) | req;

      // A request on a bit that stays pending is merged, and drop reports it.
      // A bit moving to the output this cycle is masked by clr, so a request
      // on it becomes a fresh pending entry and does not count as a drop.
      drop_d = |(req & pending_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         ptr_q     <= '0;
         idx_q     <= '0;
         out_q     <= OUT_EMPTY;
         drop_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
         drop_q    <= drop_d;
      end
   end

   assign idx         = idx_q;
   assign valid       = (out_q == OUT_FULL);
   assign any_pending = |pending_q;
   assign drop        = drop_q;

endmodule
